// File: rtl/databus.sv
// Shared execute-stage encodings: ALU operations, multiply/divide operations
// and the state encodings of the multiply/divide unit.
package databus;

  typedef enum logic [4:0] {
    ALU_add,
    ALU_addu,
    ALU_sub,
    ALU_subu,
    ALU_and,
    ALU_or,
    ALU_xor,
    ALU_nor,
    ALU_slt,
    ALU_sltu,
    ALU_sll,
    ALU_srl,
    ALU_sra,
    ALU_sllv,
    ALU_srlv,
    ALU_srav,
    ALU_lui
  } ALUOPTION;

  typedef enum logic [2:0] {
    MD_NONE,
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU,
    MD_MTHI,
    MD_MTLO
  } MDOP;

  localparam int MUL_LAT_DEFAULT = 5;

  typedef enum logic [1:0] {
    MDS_IDLE,
    MDS_MUL,
    MDS_DIV
  } md_state_t;

  typedef enum logic [1:0] {
    DV_IDLE,
    DV_SETUP,
    DV_ITER
  } div_phase_t;

  function automatic logic md_is_signed(input MDOP op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider: one setup cycle for magnitudes/signs, then one
// quotient bit per cycle. done and quot/rem are valid during the last iteration.
module mdu_divider
  import databus::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  div_phase_t       phase;
  logic [SHW-1:0]   cnt;
  logic             sgn;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic [WIDTH-1:0] raw_a;
  logic [WIDTH-1:0] raw_b;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] rem_nx;

  // Magnitude of the most negative value is itself when read as unsigned.
  assign abs_a = (sgn && raw_a[WIDTH-1]) ? -raw_a : raw_a;
  assign abs_b = (sgn && raw_b[WIDTH-1]) ? -raw_b : raw_b;

  always_comb begin
    shifted = {rem_r, quo_r[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    ge      = (shifted >= {1'b0, divisor});
    quo_nx  = {quo_r[WIDTH-2:0], ge};
    rem_nx  = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

  assign busy = (phase != DV_IDLE);
  assign done = (phase == DV_ITER) && (cnt == '0) && !flush;
  assign quot = dz ? {WIDTH{1'b1}} : (neg_q ? -quo_nx : quo_nx);
  assign rem  = dz ? raw_a : (neg_r ? -rem_nx : rem_nx);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase   <= DV_IDLE;
      cnt     <= '0;
      sgn     <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz      <= 1'b0;
      raw_a   <= '0;
      raw_b   <= '0;
      divisor <= '0;
      quo_r   <= '0;
      rem_r   <= '0;
    end else if (flush) begin
      phase <= DV_IDLE;
      cnt   <= '0;
    end else begin
      case (phase)
        DV_IDLE: begin
          if (start) begin
            raw_a <= a;
            raw_b <= b;
            sgn   <= signed_op;
            phase <= DV_SETUP;
          end
        end
        DV_SETUP: begin
          neg_q   <= sgn & (raw_a[WIDTH-1] ^ raw_b[WIDTH-1]);
          neg_r   <= sgn & raw_a[WIDTH-1];
          dz      <= (raw_b == '0);
          divisor <= abs_b;
          quo_r   <= abs_a;
          rem_r   <= '0;
          cnt     <= SHW'(WIDTH - 1);
          phase   <= DV_ITER;
        end
        DV_ITER: begin
          quo_r <= quo_nx;
          rem_r <= rem_nx;
          if (cnt == '0) begin
            phase <= DV_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: phase <= DV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with a multi-cycle multiply/divide unit and HI/LO registers.
// The ALU path is combinational; the MDU is a small IDLE/MUL/DIV machine.
module alu_mdu
  import databus::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = MUL_LAT_DEFAULT,
  localparam int SHW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  ALUOPTION         alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] alu_ans,
  output logic             overflow,
  input  MDOP              md_op,
  input  logic             md_start,
  input  logic             md_flush,
  output logic             md_busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   sv;

  assign sum  = a + b;
  assign diff = a - b;
  assign sv   = a[SHW-1:0];

  always_comb begin
    alu_ans  = '0;
    overflow = 1'b0;
    case (alu_op)
      ALU_add: begin
        alu_ans  = sum;
        overflow = ~(a[WIDTH-1] ^ b[WIDTH-1]) & (sum[WIDTH-1] ^ a[WIDTH-1]);
      end
      ALU_addu: alu_ans = sum;
      ALU_sub: begin
        alu_ans  = diff;
        overflow = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);
      end
      ALU_subu: alu_ans = diff;
      ALU_and:  alu_ans = a & b;
      ALU_or:   alu_ans = a | b;
      ALU_xor:  alu_ans = a ^ b;
      ALU_nor:  alu_ans = ~(a | b);
      ALU_slt:  alu_ans = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_sltu: alu_ans = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_sll:  alu_ans = b << shamt;
      ALU_srl:  alu_ans = b >> shamt;
      ALU_sra:  alu_ans = $signed(b) >>> shamt;
      ALU_sllv: alu_ans = b << sv;
      ALU_srlv: alu_ans = b >> sv;
      ALU_srav: alu_ans = $signed(b) >>> sv;
      ALU_lui:  alu_ans = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default:  alu_ans = '0;
    endcase
  end

  md_state_t          state;
  logic [CW-1:0]      mul_cnt;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] mul_a_ext;
  logic [2*WIDTH-1:0] mul_b_ext;
  logic [2*WIDTH-1:0] mul_full;
  logic               op_signed;
  logic               accept;
  logic               div_start;
  logic               div_busy;
  logic               div_done;
  logic [WIDTH-1:0]   div_quot;
  logic [WIDTH-1:0]   div_rem;

  assign op_signed = md_is_signed(md_op);
  assign accept    = md_start && (state == MDS_IDLE) && !md_flush && (md_op != MD_NONE);
  assign div_start = accept && ((md_op == MD_DIV) || (md_op == MD_DIVU));
  assign md_busy   = (state != MDS_IDLE);

  // Product is formed at accept and held while the countdown runs, so the
  // multiplier logic can be retimed across the idle latency stages.
  assign mul_a_ext = {{WIDTH{op_signed & a[WIDTH-1]}}, a};
  assign mul_b_ext = {{WIDTH{op_signed & b[WIDTH-1]}}, b};
  assign mul_full  = mul_a_ext * mul_b_ext;

  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start),
    .signed_op (op_signed),
    .flush     (md_flush),
    .a         (a),
    .b         (b),
    .busy      (div_busy),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= MDS_IDLE;
      mul_cnt <= '0;
      prod_q  <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (md_flush) begin
      state   <= MDS_IDLE;
      mul_cnt <= '0;
    end else begin
      case (state)
        MDS_IDLE: begin
          if (accept) begin
            case (md_op)
              MD_MTHI: hi <= a;
              MD_MTLO: lo <= a;
              MD_MULT, MD_MULTU: begin
                prod_q  <= mul_full;
                mul_cnt <= CW'(MUL_LAT - 1);
                state   <= MDS_MUL;
              end
              MD_DIV, MD_DIVU: state <= MDS_DIV;
              default: state <= MDS_IDLE;
            endcase
          end
        end
        MDS_MUL: begin
          if (mul_cnt == '0) begin
            {hi, lo} <= prod_q;
            state    <= MDS_IDLE;
          end else begin
            mul_cnt <= mul_cnt - 1'b1;
          end
        end
        MDS_DIV: begin
          if (div_done) begin
            hi    <= div_rem;
            lo    <= div_quot;
            state <= MDS_IDLE;
          end else if (!div_busy) begin
            state <= MDS_IDLE;
          end
        end
        default: state <= MDS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: a WIDTH=32 and a WIDTH=16 instance share the
// clock and reset; expected values are hand-computed constants.
module tb_alu_mdu;
  import databus::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  ALUOPTION    alu_op;
  logic [31:0] a, b, alu_ans, hi, lo;
  logic [4:0]  shamt;
  logic        overflow, md_start, md_flush, md_busy;
  MDOP         md_op;

  ALUOPTION    alu_op16;
  logic [15:0] a16, b16, alu_ans16, hi16, lo16;
  logic [3:0]  shamt16;
  logic        overflow16, md_start16, md_flush16, md_busy16;
  MDOP         md_op16;

  int n_cmp = 0;
  int n_err = 0;
  int bc;

  alu_mdu #(.WIDTH(32), .MUL_LAT(5)) dut32 (
    .clk(clk), .reset_n(reset_n), .alu_op(alu_op), .a(a), .b(b), .shamt(shamt),
    .alu_ans(alu_ans), .overflow(overflow), .md_op(md_op), .md_start(md_start),
    .md_flush(md_flush), .md_busy(md_busy), .hi(hi), .lo(lo)
  );

  alu_mdu #(.WIDTH(16), .MUL_LAT(5)) dut16 (
    .clk(clk), .reset_n(reset_n), .alu_op(alu_op16), .a(a16), .b(b16), .shamt(shamt16),
    .alu_ans(alu_ans16), .overflow(overflow16), .md_op(md_op16), .md_start(md_start16),
    .md_flush(md_flush16), .md_busy(md_busy16), .hi(hi16), .lo(lo16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_chk(input string tag, input ALUOPTION op, input logic [31:0] oa,
                         input logic [31:0] ob, input logic [4:0] sa,
                         input logic [31:0] exp_ans, input logic exp_ovf);
    alu_op = op; a = oa; b = ob; shamt = sa;
    #1;
    check({tag, "_ans"}, alu_ans, exp_ans);
    check({tag, "_ovf"}, overflow, exp_ovf);
  endtask

  // Issues one op, then counts cycles with md_busy high (bounded).
  task automatic md_run(input bit w16, input MDOP op, input logic [31:0] oa,
                        input logic [31:0] ob, output int busy_cycles);
    if (w16) begin
      md_op16 = op; a16 = oa[15:0]; b16 = ob[15:0]; md_start16 = 1'b1;
    end else begin
      md_op = op; a = oa; b = ob; md_start = 1'b1;
    end
    tick();
    md_start = 1'b0;
    md_start16 = 1'b0;
    busy_cycles = 0;
    while ((w16 ? md_busy16 : md_busy) && busy_cycles < 200) begin
      busy_cycles++;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    alu_op = ALU_add; a = '0; b = '0; shamt = '0;
    md_op = MD_NONE; md_start = 1'b0; md_flush = 1'b0;
    alu_op16 = ALU_add; a16 = '0; b16 = '0; shamt16 = '0;
    md_op16 = MD_NONE; md_start16 = 1'b0; md_flush16 = 1'b0;
    repeat (3) tick();
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", md_busy, 0);
    check("rst_hi16", hi16, 0);
    reset_n = 1'b1;
    tick();

    alu_chk("add_ovf", ALU_add, 32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 1);
    alu_chk("addu", ALU_addu, 32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 0);
    alu_chk("sub_ovf", ALU_sub, 32'h8000_0000, 32'h1, 0, 32'h7FFF_FFFF, 1);
    alu_chk("sub", ALU_sub, 32'd5, 32'd7, 0, 32'hFFFF_FFFE, 0);
    alu_chk("sra", ALU_sra, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 0);
    alu_chk("srl", ALU_srl, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 0);
    alu_chk("sllv", ALU_sllv, 32'd33, 32'h1, 5'd7, 32'h2, 0);
    alu_chk("slt", ALU_slt, 32'hFFFF_FFFF, 32'h1, 0, 32'h1, 0);
    alu_chk("sltu", ALU_sltu, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 0);
    alu_chk("nor", ALU_nor, 32'h0, 32'h0, 0, 32'hFFFF_FFFF, 0);
    alu_chk("lui", ALU_lui, 32'h0, 32'h0000_ABCD, 0, 32'hABCD_0000, 0);
    alu_chk("undef", ALUOPTION'(5'd31), 32'h1234, 32'h5678, 0, 32'h0, 0);
    alu_op16 = ALU_add; a16 = 16'h7FFF; b16 = 16'h0001;
    #1;
    check("add16_ans", alu_ans16, 16'h8000);
    check("add16_ovf", overflow16, 1);

    md_run(0, MD_MTHI, 32'h1234, 0, bc);
    check("mthi_busy", bc, 0);
    check("mthi_hi", hi, 32'h1234);
    md_run(0, MD_MTLO, 32'h5678, 0, bc);
    check("mtlo_busy", bc, 0);
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_hi_kept", hi, 32'h1234);
    md_run(0, MD_NONE, 32'hAAAA, 0, bc);
    check("none_busy", bc, 0);
    check("none_hi_kept", hi, 32'h1234);

    // Flush mid-divide; an illegal start while busy must also be dropped.
    md_op = MD_DIV; a = 32'd100; b = 32'd7; md_start = 1'b1;
    tick();
    md_op = MD_MTHI; a = 32'hDEAD;
    tick();
    md_start = 1'b0;
    repeat (8) tick();
    check("flush_pre_busy", md_busy, 1);
    md_flush = 1'b1;
    tick();
    md_flush = 1'b0;
    check("flush_busy", md_busy, 0);
    check("flush_hi", hi, 32'h1234);
    check("flush_lo", lo, 32'h5678);
    repeat (40) tick();
    check("flush_late_hi", hi, 32'h1234);
    check("flush_late_lo", lo, 32'h5678);

    // Flush on the completion edge wins.
    md_op = MD_DIV; a = 32'hFFFF_FFF9; b = 32'd2; md_start = 1'b1;
    tick();
    md_start = 1'b0;
    repeat (32) tick();
    check("flushdone_pre_busy", md_busy, 1);
    md_flush = 1'b1;
    tick();
    md_flush = 1'b0;
    check("flushdone_busy", md_busy, 0);
    check("flushdone_hi", hi, 32'h1234);
    check("flushdone_lo", lo, 32'h5678);

    md_run(0, MD_MULT, 32'hFFFF_FFFD, 32'd7, bc);
    check("mult_busy", bc, 5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    md_run(0, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h1);
    md_run(0, MD_DIV, 32'hFFFF_FFF9, 32'd2, bc);
    check("div_busy", bc, 33);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    md_run(0, MD_DIV, 32'd7, 32'hFFFF_FFFE, bc);
    check("div_negb_lo", lo, 32'hFFFF_FFFD);
    check("div_negb_hi", hi, 32'h1);
    md_run(0, MD_DIVU, 32'd100, 32'd7, bc);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    md_run(0, MD_DIVU, 32'd5, 32'd0, bc);
    check("divz_lo", lo, 32'hFFFF_FFFF);
    check("divz_hi", hi, 32'd5);
    md_run(0, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc);
    check("divmin_lo", lo, 32'h8000_0000);
    check("divmin_hi", hi, 32'h0);

    md_run(1, MD_MULT, 32'hFFFD, 32'd7, bc);
    check("mult16_busy", bc, 5);
    check("mult16_hi", hi16, 16'hFFFF);
    check("mult16_lo", lo16, 16'hFFEB);
    md_run(1, MD_MULTU, 32'hFFFF, 32'hFFFF, bc);
    check("multu16_hi", hi16, 16'hFFFE);
    check("multu16_lo", lo16, 16'h0001);
    md_run(1, MD_DIV, 32'hFFF9, 32'd2, bc);
    check("div16_busy", bc, 17);
    check("div16_lo", lo16, 16'hFFFD);
    check("div16_hi", hi16, 16'hFFFF);
    md_run(1, MD_DIVU, 32'd5, 32'd0, bc);
    check("divz16_lo", lo16, 16'hFFFF);
    check("divz16_hi", hi16, 16'h0005);
    md_run(1, MD_DIV, 32'h8000, 32'hFFFF, bc);
    check("divmin16_lo", lo16, 16'h8000);
    check("divmin16_hi", hi16, 16'h0000);

    // Reset in the middle of a multiply discards it.
    md_op = MD_MULT; a = 32'd3; b = 32'd5; md_start = 1'b1;
    tick();
    md_start = 1'b0;
    tick();
    check("rstmul_pre_busy", md_busy, 1);
    reset_n = 1'b0;
    tick();
    check("rstmul_hi", hi, 0);
    check("rstmul_lo", lo, 0);
    check("rstmul_busy", md_busy, 0);
    check("rstmul_lo16", lo16, 0);
    reset_n = 1'b1;
    repeat (10) tick();
    check("rstmul_late_lo", lo, 0);
    check("rstmul_late_busy", md_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
